// File: rtl/conf_reg_sink.sv
// ============================================================================
// Module   : conf_reg_sink
// Purpose  : CONF write-stream sink; FIFO-buffered commits into a register
//            bank with registered readback and out-of-range drop counter.
//            Optional macro CONF_BYPASS_EN: commit at the accept edge when
//            the FIFO is empty and hold is low.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conf_reg_sink #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           c_valid,
  input  logic [ADDR_WIDTH-1:0]          c_addr,
  input  logic [DATA_WIDTH-1:0]          c_data,
  output logic                           c_ready,
  input  logic                           hold,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [7:0]                     err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]      c_full_lvl = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_num_regs = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic [7:0]            r_err_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_accept;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_commit_en;
  logic [ADDR_WIDTH-1:0] w_commit_addr;
  logic [DATA_WIDTH-1:0] w_commit_data;
  logic                  w_commit_oob;
  logic [DATA_WIDTH-1:0] w_rd_sel;

  assign c_ready  = ~rst & (r_level != c_full_lvl);
  assign w_accept = c_valid & c_ready;
  assign w_pop    = (r_level != '0) & ~hold;

`ifdef CONF_BYPASS_EN
  // Only an idle, unheld sink may short-circuit the FIFO; this keeps ordering.
  assign w_bypass = w_accept & (r_level == '0) & ~hold;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push        = w_accept & ~w_bypass;
  assign w_commit_en   = w_pop | w_bypass;
  assign w_commit_addr = w_pop ? r_fifo_addr[r_rptr] : c_addr;
  assign w_commit_data = w_pop ? r_fifo_data[r_rptr] : c_data;
  assign w_commit_oob  = w_commit_en & ({1'b0, w_commit_addr} >= c_num_regs);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= c_addr;
      r_fifo_data[r_wptr] <= c_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_commit_oob && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_reg <= '0;
      end else if (w_commit_en && (w_commit_addr == ADDR_WIDTH'(gi))) begin
        r_reg <= w_commit_data;
      end
    end

    assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_reg;
  end

  // Unmatched addresses fall through to zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) w_rd_sel = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_rd_sel;
  end

  assign rd_data    = r_rd_data;
  assign fifo_level = r_level;
  assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: doc/conf_reg_sink.md
Name: conf_reg_sink

Overview:
- Downstream consumer of the CONF write stream, i.e. the c_valid/c_addr/c_data/c_ready handshake.
- Buffers accepted configuration writes in a small FIFO and commits them, one per cycle, into a register bank.
- Flattened register contents feed the datapath; a registered read port serves debug/readback.
- Writes to out-of-range addresses are dropped and counted.

Parameters:
- ADDR_WIDTH, 4, width of c_addr and rd_addr.
- DATA_WIDTH, 16, width of c_data and each register.
- NUM_REGS, 12, number of implemented registers (must be <= 2**ADDR_WIDTH).
- FIFO_DEPTH, 4, write buffer entries (power of 2, >= 2).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- c_valid  input  1  write request valid.
- c_addr  input  ADDR_WIDTH  register address.
- c_data  input  DATA_WIDTH  write data.
- c_ready  output  1  sink can accept; transfer when c_valid && c_ready at posedge.
- hold  input  1  freeze commits (FIFO still accepts until full).
- regs_flat  output  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_addr  input  ADDR_WIDTH  readback address.
- rd_data  output  DATA_WIDTH  readback data, 1-cycle latency.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_cnt  output  8  saturating count of dropped out-of-range writes.

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset values: all registers 0, FIFO empty, fifo_level 0, err_cnt 0, rd_data 0. c_ready is 1 in the cycle after reset is released.
- c_ready = (fifo_level != FIFO_DEPTH), combinational from state only; it never depends on c_valid.
- While rst is high, c_ready is 0.
- Push: on a posedge with c_valid && c_ready, {c_addr, c_data} is written at the FIFO tail.
- Pop/commit: on each posedge with FIFO non-empty and hold low, the head entry is removed.
  - c_addr < NUM_REGS: register updated at that edge.
  - c_addr >= NUM_REGS: data discarded; err_cnt += 1, saturating at 255.
- Latency: a write accepted at edge E into an empty FIFO, with hold low, is committed at edge E+1. regs_flat shows the new value after E+1.
- Simultaneous push and pop is allowed whenever not full; fifo_level is unchanged.
- When full, no push occurs even if a pop happens in the same cycle; c_ready is 1 again on the following cycle.
- Ordering: strictly FIFO. Two writes to the same address commit in arrival order, and the last one wins.
- hold high: no commits; FIFO fills up to FIFO_DEPTH, then c_ready drops. Releasing hold resumes draining at the next edge.
- Readback: rd_data at edge E+1 = register[rd_addr] as it stood before edge E+1's commit. It reflects registers, not FIFO contents.
  - rd_addr >= NUM_REGS returns 0.
- Reset mid-operation: pending FIFO entries are discarded with no commit; registers return to 0.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is computed from push/pop, not pointer difference alone, so full and empty are distinguishable.

Optional Feature:
- Macro: CONF_BYPASS_EN.
- Defined:
  - FIFO empty, hold low, and a valid transfer: the write commits directly at the accept edge E.
  - The FIFO is not written and fifo_level stays 0. Out-of-range writes still bump err_cnt at E.
  - If the FIFO is non-empty, normal queued behaviour applies, so ordering is preserved.
- Not defined: every write passes through the FIFO; latency is as stated above.

Test Plan:
- Reset then single write addr=3, data=0xBEEF, hold=0 → c_ready=1 post-reset; reg3=0xBEEF visible after accept edge + 1 (same edge with CONF_BYPASS_EN); fifo_level returns to 0.
- hold=1, c_valid held high with 5 writes addr 0..4, data 0x10..0x14 → 4 accepted, c_ready=0, fifo_level=4, regs unchanged. Release hold → regs 0..3 commit on consecutive edges; 5th write accepted once c_ready=1; reg4=0x14.
- Write addr=12 then addr=15 (NUM_REGS=12) → no register changes, err_cnt=2. Then 300 such writes → err_cnt saturates at 255.
- Back-to-back writes addr=5: 0x1111 then 0x2222 → reg5 ends at 0x2222. rd_addr=5 shows 0x1111 then 0x2222 with 1-cycle lag.
- Fill FIFO with hold=1, assert rst for 1 cycle, then release hold → fifo_level=0, all regs 0, err_cnt 0, no stale commits.
- Continuous c_valid with hold=0 for 20 writes → c_ready stays 1, throughput one write/cycle, fifo_level never exceeds 1.
